da_csa_resolve: RTL and testbench



---
 rtl/da_pkg.sv | 21 ++
 rtl/cs_resolve_add.sv | 41 ++++
 rtl/da_csa_resolve.sv | 77 +++++++
 tb/tb_da_csa_resolve.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// da_pkg: shared constants, state encoding and saturating subtract for the DA resolve stage
package da_pkg;
    localparam int RW    = 11;
    localparam int NBITS = 8;
    localparam int OW    = 12;
    localparam int LOW   = 6;
    localparam int CW    = $clog2(NBITS);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACC  = 3'd1;
    localparam logic [2:0] ADD1 = 3'd2;
    localparam logic [2:0] ADD2 = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;
    localparam logic [OW-1:0] SAT_MAX = 12'h7FF;
    localparam logic [OW-1:0] SAT_MIN = 12'h800;
    // Returns {clipped, d - y saturated to OW bits}
    function automatic logic [OW:0] sat_sub(input logic [OW-1:0] d, input logic [OW-1:0] y);
        logic [OW:0] e;
        e = {d[OW-1], d} - {y[OW-1], y};
        return (e[OW] != e[OW-1]) ? {1'b1, e[OW] ? SAT_MIN : SAT_MAX} : {1'b0, e[OW-1:0]};
    endfunction
endpackage

// File: rtl/cs_resolve_add.sv
// cs_resolve_add: two-stage sign-extend-and-add that resolves a carry-save pair
module cs_resolve_add
    import da_pkg::*;
(
    input  logic          clk,
    input  logic          r,
    input  logic          en1,
    input  logic          en2,
    input  logic [RW-1:0] a,
    input  logic [RW-1:0] b,
    output logic [OW-1:0] s,
    output logic [OW-1:0] y
);
    logic [OW-1:0] ax, bx;
    logic [LOW:0] lo_sum;
    logic [LOW-1:0] lo_q;
    logic c_q;
    logic [OW-LOW-1:0] ah_q, bh_q;
    assign ax = {{(OW-RW){a[RW-1]}}, a};
    assign bx = {{(OW-RW){b[RW-1]}}, b};
    assign lo_sum = {1'b0, ax[LOW-1:0]} + {1'b0, bx[LOW-1:0]};
    // Upper half wraps mod 2^OW; the carry-out is intentionally dropped
    assign s = {ah_q + bh_q + {{(OW-LOW-1){1'b0}}, c_q}, lo_q};
    always_ff @(posedge clk) begin
        if (!r) begin
            lo_q <= '0;
            c_q  <= 1'b0;
            ah_q <= '0;
            bh_q <= '0;
            y    <= '0;
        end else begin
            if (en1) begin
                lo_q <= lo_sum[LOW-1:0];
                c_q  <= lo_sum[LOW];
                ah_q <= ax[OW-1:LOW];
                bh_q <= bx[OW-1:LOW];
            end
            if (en2) y <= s;
        end
    end
endmodule

// File: rtl/da_csa_resolve.sv
// da_csa_resolve: counts DA accumulation cycles, resolves the sum/carry pair and emits y/saturated error
module da_csa_resolve
    import da_pkg::*;
(
    input  logic          clk,
    input  logic          r,
    input  logic          start,
    input  logic [RW-1:0] sum_in,
    input  logic [RW-1:0] carry_in,
    input  logic [OW-1:0] d_in,
    input  logic          out_ready,
    output logic [OW-1:0] y,
    output logic [OW-1:0] err,
    output logic          out_valid,
    output logic          ovf,
    output logic          busy
);
    logic [2:0] st;
    logic [CW-1:0] cnt;
    logic [RW-1:0] sum_q, carry_q;
    logic [OW-1:0] d_q, s;
    logic [OW:0] es;
    cs_resolve_add u_add (
        .clk(clk),
        .r(r),
        .en1(st == ADD1),
        .en2(st == ADD2),
        .a(sum_q),
        .b(carry_q),
        .s(s),
        .y(y)
    );
    assign es = sat_sub(d_q, s);
    always_ff @(posedge clk) begin
        if (!r) begin
            st        <= IDLE;
            cnt       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            d_q       <= '0;
            err       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= st != IDLE;
            case (st)
                IDLE: if (start) begin
                    st  <= ACC;
                    cnt <= '0;
                end
                ACC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NBITS-1)) begin
                        sum_q   <= sum_in;
                        carry_q <= carry_in;
                        d_q     <= d_in;
                        st      <= ADD1;
                    end
                end
                ADD1: st <= ADD2;
                ADD2: begin
                    err       <= es[OW-1:0];
                    ovf       <= es[OW];
                    out_valid <= 1'b1;
                    st        <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    cnt       <= '0;
                    st        <= start ? ACC : IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_da_csa_resolve.sv
// tb_da_csa_resolve: directed self-checking bench for da_csa_resolve
module tb_da_csa_resolve;
    import da_pkg::*;
    logic clk = 0, r = 0, start = 0, out_ready = 0;
    logic [RW-1:0] sum_in = '0, carry_in = '0;
    logic [OW-1:0] d_in = '0;
    logic [OW-1:0] y, err;
    logic out_valid, ovf, busy;
    int checks = 0, errors = 0;
    int n, seen;
    logic [OW-1:0] hy, he;
    logic ho;
    da_csa_resolve dut (
        .clk(clk), .r(r), .start(start), .sum_in(sum_in), .carry_in(carry_in),
        .d_in(d_in), .out_ready(out_ready), .y(y), .err(err),
        .out_valid(out_valid), .ovf(ovf), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic wait_valid(input string tag);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 10);
    endtask
    task automatic run(input string tag, input logic [RW-1:0] s, input logic [RW-1:0] c,
                       input logic [OW-1:0] d, input logic [OW-1:0] ey,
                       input logic [OW-1:0] ee, input logic eo);
        start = 1;
        tick();
        start = 0;
        sum_in = s;
        carry_in = c;
        d_in = d;
        wait_valid(tag);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_err"}, err, ee);
        chk({tag, "_ovf"}, ovf, eo);
    endtask
    task automatic accept(input string tag);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk({tag, "_acc_valid"}, out_valid, 0);
        chk({tag, "_acc_busy"}, busy, 1);
        tick();
        chk({tag, "_idle_busy"}, busy, 0);
    endtask
    initial begin
        r = 0;
        tick();
        tick();
        chk("rst_y", y, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        r = 1;
        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        chk("mid_cnt", dut.cnt, 4);
        r = 0;
        tick();
        chk("abort_st", dut.st, IDLE);
        chk("abort_valid", out_valid, 0);
        chk("abort_y", y, 0);
        chk("abort_err", err, 0);
        chk("abort_busy", busy, 0);
        r = 1;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_out", seen, 0);
        run("a", 11'h005, 11'h003, 12'd20, 12'h008, 12'h00C, 0);
        accept("a");
        run("b", 11'h7FF, 11'h7FF, 12'h000, 12'hFFE, 12'h002, 0);
        accept("b");
        run("c", 11'h400, 11'h400, 12'h7FF, 12'h800, 12'h7FF, 1);
        accept("c");
        run("d", 11'h3FF, 11'h3FF, 12'h800, 12'h7FE, 12'h800, 1);
        hy = 12'h7FE;
        he = 12'h800;
        ho = 1;
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_y", y, hy);
            chk("bp_err", err, he);
            chk("bp_ovf", ovf, ho);
        end
        start = 1;
        out_ready = 1;
        tick();
        start = 0;
        out_ready = 0;
        chk("hs_valid", out_valid, 0);
        chk("hs_st", dut.st, ACC);
        chk("hs_cnt", dut.cnt, 0);
        sum_in = 11'h002;
        carry_in = 11'h7FD;
        d_in = 12'hFFF;
        wait_valid("e");
        chk("e_y", y, 12'hFFF);
        chk("e_err", err, 12'h000);
        chk("e_ovf", ovf, 0);
        accept("e");
        start = 1;
        tick();
        start = 0;
        sum_in = 11'h010;
        carry_in = 11'h001;
        d_in = 12'h000;
        repeat (8) tick();
        chk("f_in_add1", dut.st, ADD1);
        start = 1;
        tick();
        start = 0;
        tick();
        chk("f_valid", out_valid, 1);
        chk("f_y", y, 12'h011);
        chk("f_err", err, 12'hFEF);
        accept("f");
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("f_single", seen, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
